// File: rtl/soc_isa_pkg.sv
// Shared definitions for the 19-bit ISA: field layout, opcode constants and
// the accelerator-op classifier used by the issue logic.
package soc_isa_pkg;

  localparam int INSN_W    = 19;
  localparam int OPC_W     = 5;
  localparam int REG_IDX_W = 3;

  // Instruction layout: opcode[18:14] rd[13:11] rs1[10:8] rs2[7:5] imm[4:0]
  localparam int OPC_LSB = 14;
  localparam int RD_LSB  = 11;
  localparam int RS1_LSB = 8;
  localparam int RS2_LSB = 5;

  localparam logic [OPC_W-1:0] OP_FFT   = 5'b11000;
  localparam logic [OPC_W-1:0] OP_CRYPT = 5'b11001;

  typedef enum logic {
    ACC_IDLE = 1'b0,
    ACC_BUSY = 1'b1
  } acc_state_e;

  function automatic logic is_acc(input logic [OPC_W-1:0] opc);
    return (opc == OP_FFT) || (opc == OP_CRYPT);
  endfunction

endpackage

// File: rtl/id_hazard_ctrl_if.sv
// Decode/writeback/accelerator signals between the ID stage and the hazard
// controller. master = decode side, slave = hazard controller.
interface id_hazard_ctrl_if #(
  parameter int NREG  = 8,
  parameter int CNT_W = 16
);
  localparam int RW = $clog2(NREG);

  logic             id_valid;
  logic [4:0]       id_opcode;
  logic [RW-1:0]    id_rd;
  logic [RW-1:0]    id_rs1;
  logic [RW-1:0]    id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic             id_writes_rd;
  logic             flush;
  logic             wb_valid;
  logic [RW-1:0]    wb_rd;
  logic             acc_done;

  logic             id_ready;
  logic             issue;
  logic             stall_raw;
  logic             stall_acc;
  logic [NREG-1:0]  pending;
  logic             acc_busy;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_valid, id_opcode, id_rd, id_rs1, id_rs2,
           id_uses_rs1, id_uses_rs2, id_writes_rd, flush,
           wb_valid, wb_rd, acc_done,
    input  id_ready, issue, stall_raw, stall_acc, pending, acc_busy, stall_count
  );

  modport slave (
    input  id_valid, id_opcode, id_rd, id_rs1, id_rs2,
           id_uses_rs1, id_uses_rs2, id_writes_rd, flush,
           wb_valid, wb_rd, acc_done,
    output id_ready, issue, stall_raw, stall_acc, pending, acc_busy, stall_count
  );
endinterface

// File: rtl/scoreboard_regs.sv
// Pending-write scoreboard: one bit per register, clear-on-writeback,
// set-on-issue (set wins), plus three hazard lookups with writeback bypass.
module scoreboard_regs #(
  parameter int NREG = 8,
  parameter int RW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            set_en,
  input  logic [RW-1:0]   set_idx,
  input  logic            clr_en,
  input  logic [RW-1:0]   clr_idx,
  input  logic [RW-1:0]   q0_idx,
  input  logic [RW-1:0]   q1_idx,
  input  logic [RW-1:0]   q2_idx,
  output logic            q0_hz,
  output logic            q1_hz,
  output logic            q2_hz,
  output logic [NREG-1:0] pending
);

  logic [NREG-1:0] pending_q;
  logic [NREG-1:0] pending_d;

  always_comb begin
    pending_d = pending_q;
    if (clr_en && (clr_idx != '0)) pending_d[clr_idx] = 1'b0;
    if (set_en && (set_idx != '0)) pending_d[set_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  // A same-cycle writeback forwards through the register file, so it hides the hazard.
  always_comb begin
    q0_hz = pending_q[q0_idx] & !(clr_en && (clr_idx == q0_idx));
    q1_hz = pending_q[q1_idx] & !(clr_en && (clr_idx == q1_idx));
    q2_hz = pending_q[q2_idx] & !(clr_en && (clr_idx == q2_idx));
  end

  assign pending = pending_q;

endmodule

// File: rtl/id_hazard_ctrl.sv
// ID-stage issue controller: RAW/WAW interlock via scoreboard, serialisation
// of the shared accelerator, and a saturating stall-cycle counter.
module id_hazard_ctrl
  import soc_isa_pkg::*;
#(
  parameter int NREG  = 8,
  parameter int CNT_W = 16
) (
  input logic             clk,
  input logic             rst_n,
  id_hazard_ctrl_if.slave bus
);

  logic       hz_rs1, hz_rs2, hz_rd;
  logic       is_acc_op, acc_issue, stall_inc;
  logic       stall_raw, stall_acc, id_ready, issue;
  acc_state_e acc_state_q, acc_state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [NREG-1:0]  pending;

  scoreboard_regs #(
    .NREG (NREG)
  ) u_scoreboard (
    .clk     (clk),
    .rst_n   (rst_n),
    .set_en  (issue & bus.id_writes_rd),
    .set_idx (bus.id_rd),
    .clr_en  (bus.wb_valid),
    .clr_idx (bus.wb_rd),
    .q0_idx  (bus.id_rs1),
    .q1_idx  (bus.id_rs2),
    .q2_idx  (bus.id_rd),
    .q0_hz   (hz_rs1),
    .q1_hz   (hz_rs2),
    .q2_hz   (hz_rd),
    .pending (pending)
  );

  always_comb begin
    is_acc_op = is_acc(bus.id_opcode);
    stall_raw = bus.id_valid & ((bus.id_uses_rs1  & hz_rs1) |
                                (bus.id_uses_rs2  & hz_rs2) |
                                (bus.id_writes_rd & hz_rd));
    // acc_done frees the accelerator in time for a waiting op to issue this cycle.
    stall_acc = bus.id_valid & is_acc_op & (acc_state_q == ACC_BUSY) & !bus.acc_done;
    id_ready  = bus.id_valid & !(stall_raw | stall_acc);
    issue     = id_ready & !bus.flush;
    acc_issue = issue & is_acc_op;
    stall_inc = bus.id_valid & !id_ready & !bus.flush;
  end

  always_comb begin
    acc_state_d = acc_state_q;
    case (acc_state_q)
      ACC_IDLE: if (acc_issue) acc_state_d = ACC_BUSY;
      ACC_BUSY: if (bus.acc_done && !acc_issue) acc_state_d = ACC_IDLE;
      default:  acc_state_d = ACC_IDLE;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_inc && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_state_q <= ACC_IDLE;
      stall_cnt_q <= '0;
    end else begin
      acc_state_q <= acc_state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.id_ready    = id_ready;
  assign bus.issue       = issue;
  assign bus.stall_raw   = stall_raw;
  assign bus.stall_acc   = stall_acc;
  assign bus.pending     = pending;
  assign bus.acc_busy    = (acc_state_q == ACC_BUSY);
  assign bus.stall_count = stall_cnt_q;

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Scoreboard bench for id_hazard_ctrl: a behavioural reference produces the
// expected outputs per driven cycle; they are queued and compared at negedge.
module tb_id_hazard_ctrl;

  localparam int NREG  = 8;
  localparam int CNT_W = 16;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  id_hazard_ctrl_if #(.NREG(NREG), .CNT_W(CNT_W)) bus ();

  id_hazard_ctrl #(.NREG(NREG), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             rdy;
    logic             iss;
    logic             raw;
    logic             acc;
    logic [NREG-1:0]  pend;
    logic             busy;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t sb_q[$];

  logic [NREG-1:0]  m_pending;
  logic             m_busy;
  logic [CNT_W-1:0] m_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic m_hz(input logic [2:0] x);
    return m_pending[x] & !(bus.wb_valid && bus.wb_rd == x);
  endfunction

  task automatic clr();
    bus.id_valid = 0; bus.id_opcode = '0; bus.id_rd = '0; bus.id_rs1 = '0; bus.id_rs2 = '0;
    bus.id_uses_rs1 = 0; bus.id_uses_rs2 = 0; bus.id_writes_rd = 0; bus.flush = 0;
    bus.wb_valid = 0; bus.wb_rd = '0; bus.acc_done = 0;
  endtask

  // Inputs are already driven (just after a posedge); run one clock cycle.
  task automatic cycle();
    exp_t e;
    exp_t g;
    logic is_a, r, a, rdy, iss;
    is_a = (bus.id_opcode == 5'b11000) || (bus.id_opcode == 5'b11001);
    r    = bus.id_valid & ((bus.id_uses_rs1 & m_hz(bus.id_rs1)) |
                           (bus.id_uses_rs2 & m_hz(bus.id_rs2)) |
                           (bus.id_writes_rd & m_hz(bus.id_rd)));
    a    = bus.id_valid & is_a & m_busy & !bus.acc_done;
    rdy  = bus.id_valid & !(r | a);
    iss  = rdy & !bus.flush;
    e.rdy = rdy; e.iss = iss; e.raw = r; e.acc = a;
    e.pend = m_pending; e.busy = m_busy; e.cnt = m_cnt;
    sb_q.push_back(e);

    @(negedge clk);
    g = sb_q.pop_front();
    check_eq("id_ready",    32'(bus.id_ready),    32'(g.rdy));
    check_eq("issue",       32'(bus.issue),       32'(g.iss));
    check_eq("stall_raw",   32'(bus.stall_raw),   32'(g.raw));
    check_eq("stall_acc",   32'(bus.stall_acc),   32'(g.acc));
    check_eq("pending",     32'(bus.pending),     32'(g.pend));
    check_eq("acc_busy",    32'(bus.acc_busy),    32'(g.busy));
    check_eq("stall_count", 32'(bus.stall_count), 32'(g.cnt));

    if (bus.wb_valid && bus.wb_rd != 0) m_pending[bus.wb_rd] = 1'b0;
    if (iss && bus.id_writes_rd && bus.id_rd != 0) m_pending[bus.id_rd] = 1'b1;
    if (!m_busy) m_busy = iss & is_a;
    else if (bus.acc_done && !(iss & is_a)) m_busy = 1'b0;
    if (bus.id_valid && !rdy && !bus.flush && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;

    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [CNT_W-1:0] saved;
    rst_n = 1'b0;
    clr();
    m_pending = '0; m_busy = 1'b0; m_cnt = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_pending", 32'(bus.pending), 32'h0);
    check_eq("rst_busy",    32'(bus.acc_busy), 32'h0);
    check_eq("rst_count",   32'(bus.stall_count), 32'h0);
    check_eq("rst_issue",   32'(bus.issue), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // RAW: producer, stalled consumer, release on same-cycle writeback
    clr(); bus.id_valid = 1; bus.id_writes_rd = 1; bus.id_rd = 3'd1; cycle();
    clr(); bus.id_valid = 1; bus.id_uses_rs1 = 1; bus.id_rs1 = 3'd1; cycle();
    check_eq("raw_count_1", 32'(bus.stall_count), 32'd1);
    bus.wb_valid = 1; bus.wb_rd = 3'd1;
    #1 check_eq("raw_wb_issue", 32'(bus.issue), 32'd1);
    cycle();

    // WAW with set-over-clear priority
    clr(); bus.id_valid = 1; bus.id_writes_rd = 1; bus.id_rd = 3'd3; cycle();
    clr(); bus.id_valid = 1; bus.id_writes_rd = 1; bus.id_rd = 3'd3;
    bus.wb_valid = 1; bus.wb_rd = 3'd3; cycle();
    check_eq("waw_pend3", 32'(bus.pending[3]), 32'd1);
    clr(); bus.wb_valid = 1; bus.wb_rd = 3'd3; cycle();

    // Register 0 never pending
    clr(); bus.id_valid = 1; bus.id_writes_rd = 1; bus.id_rd = 3'd0; cycle();
    clr(); bus.id_valid = 1; bus.id_uses_rs2 = 1; bus.id_rs2 = 3'd0; cycle();
    check_eq("r0_pending", 32'(bus.pending), 32'h00);

    // Accelerator serialisation
    clr(); bus.id_valid = 1; bus.id_opcode = 5'b11000; cycle();
    check_eq("acc_busy_set", 32'(bus.acc_busy), 32'd1);
    clr(); bus.id_valid = 1; bus.id_opcode = 5'b11001; cycle();
    clr(); bus.id_valid = 1; bus.id_opcode = 5'b11001; bus.acc_done = 1; cycle();
    check_eq("acc_busy_hold", 32'(bus.acc_busy), 32'd1);
    clr(); bus.acc_done = 1; cycle();
    clr(); bus.acc_done = 1; cycle();
    check_eq("acc_idle_done", 32'(bus.acc_busy), 32'd0);

    // Flush during RAW stall leaves the counter alone
    clr(); bus.id_valid = 1; bus.id_writes_rd = 1; bus.id_rd = 3'd2; cycle();
    saved = bus.stall_count;
    clr(); bus.id_valid = 1; bus.id_uses_rs1 = 1; bus.id_rs1 = 3'd2; bus.flush = 1; cycle();
    check_eq("flush_count", 32'(bus.stall_count), 32'(saved));
    clr(); bus.id_valid = 1; bus.id_uses_rs1 = 1; bus.id_rs1 = 3'd2; cycle();
    clr(); bus.wb_valid = 1; bus.wb_rd = 3'd2; cycle();
    clr(); bus.wb_valid = 1; bus.wb_rd = 3'd6; cycle();

    // Saturation
    clr(); bus.id_valid = 1; bus.id_writes_rd = 1; bus.id_rd = 3'd5; cycle();
    clr(); bus.id_valid = 1; bus.id_uses_rs1 = 1; bus.id_rs1 = 3'd5;
    repeat (65540) cycle();
    check_eq("sat_count", 32'(bus.stall_count), 32'h0000FFFF);

    // Build pending=0E, acc busy, then async reset mid-stall
    clr(); bus.wb_valid = 1; bus.wb_rd = 3'd5; cycle();
    for (int unsigned i = 1; i <= 3; i++) begin
      clr(); bus.id_valid = 1; bus.id_writes_rd = 1; bus.id_rd = 3'(i); cycle();
    end
    clr(); bus.id_valid = 1; bus.id_opcode = 5'b11000; cycle();
    check_eq("pre_rst_pending", 32'(bus.pending), 32'h0E);
    clr(); bus.id_valid = 1; bus.id_uses_rs1 = 1; bus.id_rs1 = 3'd1;
    #1 check_eq("pre_rst_raw", 32'(bus.stall_raw), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("arst_pending", 32'(bus.pending), 32'h0);
    check_eq("arst_busy",    32'(bus.acc_busy), 32'h0);
    check_eq("arst_count",   32'(bus.stall_count), 32'h0);
    check_eq("arst_raw",     32'(bus.stall_raw), 32'h0);
    m_pending = '0; m_busy = 1'b0; m_cnt = '0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    clr(); bus.wb_valid = 1; bus.wb_rd = 3'd1; cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
